dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU port) and a
//  debug/DMA requester (DMA port). Sits between the MEM stage and DMEM; picks one access per
//  cycle, drives DMEM address/data/write-enable and routes the registered read word back to
//  whichever port issued the read. CPU has priority; DMA is served in idle cycles.
// PARAMETERS
//  DMEM_ADDR_WIDTH   12  DMEM address width
//  DMEM_WORD_WIDTH   16  DMEM word width
//  STARVE_LIMIT       4  consecutive DMA wait cycles before a forced DMA grant (DMEM_ARB_FAIR_EN only)
//  STARVE_CNT_WIDTH   3  starvation counter width; must hold STARVE_LIMIT
// PORTS
//  clock          in   1   clock
//  reset          in   1   reset, asynchronous, active-high
//  cpu_req_valid  in   1   MEM stage requests a DMEM access (load or store)
//  cpu_req_we     in   1   1 = store, 0 = load
//  cpu_addr       in   AW  CPU access address
//  cpu_wr_word    in   WW  CPU store data
//  cpu_stall      out  1   CPU request not granted this cycle; pipeline holds request
//  cpu_rd_valid   out  1   cpu_rd_word holds data of the CPU load granted last cycle
//  cpu_rd_word    out  WW  CPU load data
//  dma_req_valid  in   1   DMA requests a DMEM access
//  dma_req_we     in   1   1 = write, 0 = read
//  dma_addr       in   AW  DMA address
//  dma_wr_word    in   WW  DMA write data
//  dma_req_ready  out  1   DMA request accepted this cycle
//  dma_rd_valid   out  1   dma_rd_word holds data of the DMA read accepted last cycle
//  dma_rd_word    out  WW  DMA read data
//  mem_addr       out  AW  DMEM address
//  mem_wr_word    out  WW  DMEM write data
//  mem_write_en   out  1   DMEM write enable
//  mem_rd_word    in   WW  DMEM read data (synchronous read, valid cycle after address)
// BEHAVIOUR
//  - Grant is combinational per cycle: grant_dma = dma_req_valid & (!cpu_req_valid | force_dma);
//    grant_cpu = cpu_req_valid & !grant_dma. force_dma = 0 unless DMEM_ARB_FAIR_EN.
//  - mem_addr/mem_wr_word mux from granted port; mem_write_en = granted & we. No grant: addr 0, we 0.
//  - cpu_stall = cpu_req_valid & grant_dma. dma_req_ready = grant_dma.
//  - DMA handshake: dma_req_valid, dma_req_we, dma_addr, dma_wr_word held stable until
//    dma_req_ready; transfer completes in the cycle both are high. CPU likewise holds while stalled.
//  - Read-owner FSM (registered, one state per cycle): RD_NONE, RD_CPU, RD_DMA. Next state = RD_CPU
//    if grant_cpu & !cpu_req_we, RD_DMA if grant_dma & !dma_req_we, else RD_NONE.
//  - cpu_rd_valid = (state == RD_CPU); dma_rd_valid = (state == RD_DMA). Read latency 1 cycle.
//    *_rd_word = mem_rd_word when own valid high, else 0. Back-to-back reads pipeline at 1/cycle.
//  - Writes produce no response; write-then-read same address returns new data next cycle.
//  - Reset: state RD_NONE, starvation counter 0; all combinational outputs follow (no grant while
//    requests low). Reset mid-read drops the pending rd_valid; no retry.
// CONFIGURATION
//  - DMEM_ARB_FAIR_EN defined: starve_cnt increments each cycle dma_req_valid & !grant_dma,
//    saturates at STARVE_LIMIT, clears on grant_dma or !dma_req_valid. force_dma = (starve_cnt ==
//    STARVE_LIMIT): DMA wins that one cycle, cpu_stall = 1 if CPU requesting, counter clears, so
//    CPU wins the next cycle. Worst-case DMA wait STARVE_LIMIT cycles.
//  - Undefined: no counter; strict CPU priority; cpu_stall constant 0; DMA may starve.
// TESTING
//  1. Reset asserted the cycle after a CPU load grant -> cpu_rd_valid 0, mem_write_en 0, FSM RD_NONE.
//  2. CPU load addr 0x010, DMEM[0x010]=0xBEEF -> mem_addr=0x010 same cycle; next cycle
//     cpu_rd_valid=1, cpu_rd_word=0xBEEF; dma_rd_valid=0.
//  3. CPU idle, DMA write 0x020<-0x1234 -> dma_req_ready=1, mem_write_en=1, mem_addr=0x020,
//     mem_wr_word=0x1234 same cycle; DMA read 0x020 next cycle -> dma_rd_word=0x1234 one later.
//  4. Both request every cycle, STARVE_LIMIT=4, FAIR_EN defined -> CPU granted cycles 0-3, DMA at
//     cycle 4 with cpu_stall=1 that cycle only, CPU again cycle 5; undefined -> dma_req_ready stays
//     0 and cpu_stall stays 0 until cpu_req_valid drops, then DMA granted that cycle.
//  5. Alternating CPU read 0x001 / DMA read 0x002 on consecutive cycles -> cpu_rd_valid and
//     dma_rd_valid alternate, each carrying its own address's data, never both high.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose: shares single-port DMEM between the MEM-stage CPU port and a debug/DMA port; CPU has priority.
// Latency: grant and DMEM drive are combinational; read data returns on the owning port one cycle after grant.
// Backpressure: CPU sees cpu_stall, DMA waits for dma_req_ready; DMEM_ARB_FAIR_EN bounds DMA starvation.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH  = 12,
    parameter int DMEM_WORD_WIDTH  = 16,
    parameter int STARVE_LIMIT     = 4,
    parameter int STARVE_CNT_WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cpu_req_valid,
    input  logic                       cpu_req_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] cpu_wr_word,
    output logic                       cpu_stall,
    output logic                       cpu_rd_valid,
    output logic [DMEM_WORD_WIDTH-1:0] cpu_rd_word,
    input  logic                       dma_req_valid,
    input  logic                       dma_req_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] dma_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] dma_wr_word,
    output logic                       dma_req_ready,
    output logic                       dma_rd_valid,
    output logic [DMEM_WORD_WIDTH-1:0] dma_rd_word,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] mem_wr_word,
    output logic                       mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] mem_rd_word
);

    // Which port owns the read word DMEM will present next cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DMA  = 2'd2
    } rd_state_t;

    rd_state_t rd_state;
    rd_state_t rd_state_nxt;
    logic      grant_cpu;
    logic      grant_dma;
    logic      force_dma;

    // The starvation counter must be able to reach its limit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << STARVE_CNT_WIDTH)) begin : g_bad_starve_cfg
        $error("dmem_arbiter: STARVE_CNT_WIDTH too narrow for STARVE_LIMIT");
    end

`ifdef DMEM_ARB_FAIR_EN
    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

    // Count consecutive cycles the DMA waits; saturate at the limit, clear once served or idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_dma || !dma_req_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A DMA that has waited the full limit wins exactly one cycle over the CPU.
    assign force_dma = (starve_cnt == STARVE_MAX);
`else
    // Strict CPU priority: the DMA only gets cycles the CPU leaves idle.
    assign force_dma = 1'b0;
`endif

    assign grant_dma     = dma_req_valid & (~cpu_req_valid | force_dma);
    assign grant_cpu     = cpu_req_valid & ~grant_dma;
    assign cpu_stall     = cpu_req_valid & grant_dma;
    assign dma_req_ready = grant_dma;

    // Read-owner register: one state per cycle, dropped on reset with no retry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state <= RD_NONE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Drive DMEM from the granted port and decide who owns next cycle's read word.
    always_comb begin
        mem_addr     = '0;
        mem_wr_word  = '0;
        mem_write_en = 1'b0;
        rd_state_nxt = RD_NONE;
        if (grant_dma) begin
            mem_addr     = dma_addr;
            mem_wr_word  = dma_wr_word;
            mem_write_en = dma_req_we;
            if (!dma_req_we) begin
                rd_state_nxt = RD_DMA;
            end
        end else if (grant_cpu) begin
            mem_addr     = cpu_addr;
            mem_wr_word  = cpu_wr_word;
            mem_write_en = cpu_req_we;
            if (!cpu_req_we) begin
                rd_state_nxt = RD_CPU;
            end
        end
    end

    assign cpu_rd_valid = (rd_state == RD_CPU);
    assign dma_rd_valid = (rd_state == RD_DMA);
    assign cpu_rd_word  = cpu_rd_valid ? mem_rd_word : '0;
    assign dma_rd_word  = dma_rd_valid ? mem_rd_word : '0;

endmodule
